// File: rtl/seg7_scan_controller_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_controller_if
// Groups the data-load handshake and the display pin signals of the
// seg7_scan_controller into a single bundle.
//   digits_in  : hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in      : decimal point request per digit
//   lz_blank   : leading-zero suppression enable, captured with the data
//   load       : capture request for digits_in/dp_in/lz_blank
//   load_ack   : one-cycle pulse when captured data becomes displayed
//   frame_done : one-cycle pulse at the end of every full scan
//   seg        : segments {g,f,e,d,c,b,a}
//   dp         : decimal point segment
//   dig_sel    : digit enables, bit i = digit i
// master = data producer / pin observer, slave = the scan controller.
// -----------------------------------------------------------------------------
interface seg7_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_blank;
    logic                    load;
    logic                    load_ack;
    logic                    frame_done;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   dig_sel;

    modport master (
        output digits_in, dp_in, lz_blank, load,
        input  load_ack, frame_done, seg, dp, dig_sel
    );

    modport slave (
        input  digits_in, dp_in, lz_blank, load,
        output load_ack, frame_done, seg, dp, dig_sel
    );
endinterface

// File: rtl/seg7_scan_controller.sv
// -----------------------------------------------------------------------------
// seg7_scan_controller
// Time-multiplexed scan scheduler for a shared 7-segment bus. Each digit gets
// a CLK_DIV-cycle slot that opens with BLANK_CYCLES of all-off (anti-ghosting)
// and then drives that digit. New data is double-buffered: a load lands in a
// shadow set and is committed to the display set only on the last cycle of a
// frame, so a frame never mixes old and new values.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : seg7_scan_controller_if.slave (load handshake + display pins)
// All pin outputs are registered, one cycle behind the counter/state.
// -----------------------------------------------------------------------------
module seg7_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 40000,
    parameter int BLANK_CYCLES = 2000,
    parameter int COMMON_ANODE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    seg7_scan_controller_if.slave        bus
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DAT_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);
    // Polarity mask: XOR with active-high values gives the pin level.
    localparam logic                  POL        = (COMMON_ANODE != 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic                    pending_r;
    logic [DAT_W-1:0]        shadow_dig_r, disp_dig_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r, disp_dp_r;
    logic                    shadow_lz_r, disp_lz_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   dig_sel_r;
    logic                    load_ack_r, frame_done_r;

    logic                    slot_last_s, frame_end_s, commit_s;
    logic [3:0]              cur_nib_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic                    zero_run_s;
    logic [6:0]              seg_act_s;
    logic                    dp_act_s;
    logic [NUM_DIGITS-1:0]   dig_act_s;

    // Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_decode = 7'h3F;
            4'h1:    seg_decode = 7'h06;
            4'h2:    seg_decode = 7'h5B;
            4'h3:    seg_decode = 7'h4F;
            4'h4:    seg_decode = 7'h66;
            4'h5:    seg_decode = 7'h6D;
            4'h6:    seg_decode = 7'h7D;
            4'h7:    seg_decode = 7'h07;
            4'h8:    seg_decode = 7'h7F;
            4'h9:    seg_decode = 7'h6F;
            4'hA:    seg_decode = 7'h77;
            4'hB:    seg_decode = 7'h7C;
            4'hC:    seg_decode = 7'h39;
            4'hD:    seg_decode = 7'h5E;
            4'hE:    seg_decode = 7'h79;
            4'hF:    seg_decode = 7'h71;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    assign slot_last_s = (cnt_r == CNT_LAST);
    assign frame_end_s = slot_last_s && (idx_r == IDX_LAST);
    // A load arriving in the commit cycle itself joins that commit.
    assign commit_s    = frame_end_s && (pending_r || bus.load);
    assign cur_nib_s   = disp_dig_r[{idx_r, 2'b00} +: 4];

    // Slot counter, digit index and FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            state_r <= ST_BLANK;
        end else begin
            state_r <= state_nxt_s;
            if (slot_last_s) begin
                cnt_r <= CNT_ZERO;
                idx_r <= (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + IDX_ONE;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Next state: enter DRIVE as the counter reaches BLANK_CYCLES, back to BLANK on wrap.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) state_nxt_s = ST_DRIVE;
                else                     state_nxt_s = ST_BLANK;
            end
            ST_DRIVE: begin
                if (slot_last_s) state_nxt_s = ST_BLANK;
                else             state_nxt_s = ST_DRIVE;
            end
            default: state_nxt_s = ST_BLANK;
        endcase
    end

    // Leading-zero mask: walk down from the top digit while digits stay 0 with dp clear.
    always_comb begin
        lz_mask_s  = {NUM_DIGITS{1'b0}};
        zero_run_s = disp_lz_r;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run_s   = zero_run_s && (disp_dig_r[4*i +: 4] == 4'h0) && !disp_dp_r[i];
            lz_mask_s[i] = zero_run_s;
        end
    end

    // Active-high pin values for the current slot (all off while blanking).
    always_comb begin
        seg_act_s = 7'h00;
        dp_act_s  = 1'b0;
        dig_act_s = {NUM_DIGITS{1'b0}};
        if (state_r == ST_DRIVE) begin
            seg_act_s = lz_mask_s[idx_r] ? 7'h00 : seg_decode(cur_nib_s);
            dp_act_s  = disp_dp_r[idx_r];
            dig_act_s = SEL_ONE << idx_r;
        end else begin
            seg_act_s = 7'h00;
            dp_act_s  = 1'b0;
            dig_act_s = {NUM_DIGITS{1'b0}};
        end
    end

    // Shadow capture and pending flag; reset drops any uncommitted load.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_dig_r <= {DAT_W{1'b0}};
            shadow_dp_r  <= {NUM_DIGITS{1'b0}};
            shadow_lz_r  <= 1'b0;
            pending_r    <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_dig_r <= bus.digits_in;
                shadow_dp_r  <= bus.dp_in;
                shadow_lz_r  <= bus.lz_blank;
            end
            if (commit_s)      pending_r <= 1'b0;
            else if (bus.load) pending_r <= 1'b1;
        end
    end

    // Display set: updated only at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_dig_r <= {DAT_W{1'b0}};
            disp_dp_r  <= {NUM_DIGITS{1'b0}};
            disp_lz_r  <= 1'b0;
        end else if (commit_s) begin
            disp_dig_r <= bus.load ? bus.digits_in : shadow_dig_r;
            disp_dp_r  <= bus.load ? bus.dp_in     : shadow_dp_r;
            disp_lz_r  <= bus.load ? bus.lz_blank  : shadow_lz_r;
        end
    end

    // Registered pins with polarity applied, plus the handshake pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r        <= {7{POL}};
            dp_r         <= POL;
            dig_sel_r    <= {NUM_DIGITS{POL}};
            load_ack_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_act_s ^ {7{POL}};
            dp_r         <= dp_act_s ^ POL;
            dig_sel_r    <= dig_act_s ^ {NUM_DIGITS{POL}};
            load_ack_r   <= commit_s;
            frame_done_r <= frame_end_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.dig_sel    = dig_sel_r;
    assign bus.load_ack   = load_ack_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_controller
// Bench for seg7_scan_controller with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2,
// COMMON_ANODE=1. Loads push the expected commit (ack cycle + data) onto a
// scoreboard queue; the entry is popped when its ack cycle comes around, and
// from then on the expected pin values are built from the popped data.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_controller;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = ND * DIV;

    logic clk;
    logic rst;

    seg7_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_controller #(
        .NUM_DIGITS  (ND),
        .CLK_DIV     (DIV),
        .BLANK_CYCLES(BLK),
        .COMMON_ANODE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-high segment patterns for hex 0..F.
    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int          ack_t;
        logic [15:0] d;
        logic [3:0]  p;
        logic        lz;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic        m_lz;
    int          t;
    logic        prev_rst;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    // Compare the pins of cycle t against the model, then retire a due commit.
    task automatic check_outputs();
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_dig;
        logic       e_fd;
        logic       e_ack;
        logic       blank;
        int         p;
        int         slot;
        int         d;
        sb_t        e;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_dig = 4'hF;
        e_fd  = 1'b0;
        e_ack = 1'b0;
        if (t >= 1) begin
            p    = t - 1;
            slot = p % DIV;
            d    = (p / DIV) % ND;
            if (slot >= BLK) begin
                e_dig = 4'hF ^ (4'b0001 << d);
                e_dp  = ~m_dp[d];
                blank = m_lz && (d != 0);
                for (int j = d; j < ND; j++) begin
                    if (m_dig[4*j +: 4] != 4'h0 || m_dp[j]) blank = 1'b0;
                end
                e_seg = blank ? 7'h7F : (7'h7F ^ dec_tab[m_dig[4*d +: 4]]);
            end
            e_fd = ((t % FRAME) == 0);
        end
        if (sb_q.size() > 0 && sb_q[0].ack_t == t) e_ack = 1'b1;
        check("seg", 32'(bus.seg), 32'(e_seg));
        check("dp", 32'(bus.dp), 32'(e_dp));
        check("dig_sel", 32'(bus.dig_sel), 32'(e_dig));
        check("one_digit", 32'($countones(~bus.dig_sel) <= 1), 32'd1);
        check("frame_done", 32'(bus.frame_done), 32'(e_fd));
        check("load_ack", 32'(bus.load_ack), 32'(e_ack));
        if (e_ack) begin
            e     = sb_q.pop_front();
            m_dig = e.d;
            m_dp  = e.p;
            m_lz  = e.lz;
        end
    endtask

    // One clock cycle: check this cycle's pins, then drive this cycle's inputs.
    task automatic step(input logic r, input logic ld, input logic [15:0] d,
                        input logic [3:0] p, input logic lz);
        sb_t e;
        int  ack;
        @(negedge clk);
        if (prev_rst) begin
            t = 0;
            sb_q.delete();
            m_dig = 16'h0000;
            m_dp  = 4'h0;
            m_lz  = 1'b0;
        end else begin
            t++;
        end
        check_outputs();
        rst          = r;
        prev_rst     = r;
        bus.load     = ld;
        bus.digits_in = ld ? d  : 16'($urandom);
        bus.dp_in     = ld ? p  : 4'($urandom);
        bus.lz_blank  = ld ? lz : 1'($urandom);
        if (ld && !r) begin
            ack = t + (FRAME - 1 - (t % FRAME)) + 1;
            if (sb_q.size() > 0 && sb_q[sb_q.size()-1].ack_t == ack) void'(sb_q.pop_back());
            e.ack_t = ack;
            e.d     = d;
            e.p     = p;
            e.lz    = lz;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle_to(input int tt);
        int nt;
        nt = prev_rst ? 0 : t + 1;
        while (nt < tt) begin
            step(1'b0, 1'b0, 16'h0000, 4'h0, 1'b0);
            nt = t + 1;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        t             = -1;
        prev_rst      = 1'b1;
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.digits_in = 16'h0000;
        bus.dp_in     = 4'h0;
        bus.lz_blank  = 1'b0;
        m_dig         = 16'h0000;
        m_dp          = 4'h0;
        m_lz          = 1'b0;

        // Reset held for three edges, then scan from cycle 0.
        step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        // Single load.
        idle_to(3);
        step(1'b0, 1'b1, 16'h4321, 4'h0, 1'b0);
        // Double load within one frame: one ack, last data wins.
        idle_to(101);
        step(1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
        idle_to(116);
        step(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
        // Load in the commit cycle itself, with leading-zero blanking.
        idle_to(159);
        step(1'b0, 1'b1, 16'h0050, 4'h0, 1'b1);
        idle_to(200);
        step(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1);
        idle_to(260);
        step(1'b0, 1'b1, 16'h0000, 4'h4, 1'b1);
        // Reset mid-frame with a load pending; a load under reset is ignored.
        idle_to(355);
        step(1'b0, 1'b1, 16'h9876, 4'hA, 1'b0);
        idle_to(372);
        step(1'b1, 1'b1, 16'h5555, 4'h0, 1'b0);
        // Ten frames of free-running scan on reset data.
        idle_to(330);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
